// File: rtl/ncl_pkg.sv
// Shared types for the dual-rail NCL receiver.
// Rail encodings, handshake state and wavefront class.
package ncl_pkg;

    localparam logic [1:0] RAIL_NULL = 2'b00;
    localparam logic [1:0] RAIL_D0   = 2'b01;
    localparam logic [1:0] RAIL_D1   = 2'b10;
    localparam logic [1:0] RAIL_ILL  = 2'b11;

    typedef enum logic {
        REQ_DATA,
        REQ_NULL
    } state_t;

    typedef enum logic [1:0] {
        ALL_NULL,
        ALL_DATA,
        PARTIAL,
        ILLEGAL
    } cls_t;

    function automatic logic digit_is_data(input logic [1:0] d);
        return (d == RAIL_D0) || (d == RAIL_D1);
    endfunction

endpackage

// File: rtl/ncl_dr_sync_receiver_if.sv
// Dual-rail channel plus decoded valid/ready stream.
// slave = receiver side, master = upstream/consumer side.
interface ncl_dr_sync_receiver_if #(
    parameter int DIGITS = 2
);
    logic [2*DIGITS-1:0] a_rail;
    logic                a_comp;
    logic [DIGITS-1:0]   out_data;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output a_rail,
        output out_ready,
        input  a_comp,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  a_rail,
        input  out_ready,
        output a_comp,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/ncl_rail_sync.sv
// Multi-flop synchronizer for a vector of async rails.
// Every flop clears on init.
module ncl_rail_sync #(
    parameter int W      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         init,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] ff [STAGES];

    // Shift the rails through the synchronizer chain
    always_ff @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < STAGES; i++) ff[i] <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
        end
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/ncl_dr_sync_receiver.sv
// Clocked sink for a dual-rail NCL channel: completion,
// decode, word FIFO, token count and protocol errors.
module ncl_dr_sync_receiver
    import ncl_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic                clk,
    input  logic                init,
    ncl_dr_sync_receiver_if.slave bus,
    output logic [15:0]         token_count,
    output logic                err_illegal,
    output logic [7:0]          err_count,
    output logic                err_timeout
);
    localparam int W  = 2 * DIGITS;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT);
    localparam logic [TW-1:0] T_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [W-1:0]      rs;
    logic [W-1:0]      rp;
    logic              stable;
    cls_t              cls;
    logic [DIGITS-1:0] dec;

    state_t            state;
    state_t            state_n;
    logic              cap;
    logic              done;

    logic [DIGITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CW-1:0]     cnt;
    logic              push_q;
    logic [DIGITS-1:0] push_w;
    logic              full;
    logic              vld;
    logic              pop;
    logic [TW-1:0]     tcnt;

    ncl_rail_sync #(
        .W      (W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .init (init),
        .d    (bus.a_rail),
        .q    (rs)
    );

    assign stable        = (rs == rp);
    assign full          = (cnt == FULL_LVL);
    assign vld           = (cnt != '0);
    assign pop           = vld & bus.out_ready;
    assign bus.out_valid = vld;
    assign bus.out_data  = mem[rptr];

    // Classify the synchronized wavefront and decode rail1 bits
    always_comb begin
        logic any_ill;
        logic all_data;
        any_ill  = 1'b0;
        all_data = 1'b1;
        dec      = '0;
        cls      = PARTIAL;
        for (int i = 0; i < DIGITS; i++) begin
            if (rs[2*i +: 2] == RAIL_ILL) any_ill = 1'b1;
            if (!digit_is_data(rs[2*i +: 2])) all_data = 1'b0;
            dec[i] = rs[2*i + 1];
        end
        unique case (1'b1)
            any_ill:     cls = ILLEGAL;
            (rs == '0):  cls = ALL_NULL;
            all_data:    cls = ALL_DATA;
            default:     cls = PARTIAL;
        endcase
    end

    // Handshake state register
    always_ff @(posedge clk) begin
        if (init) state <= REQ_DATA;
        else      state <= state_n;
    end

    // Next state: capture on stable DATA, release on stable NULL
    always_comb begin
        state_n = state;
        cap     = 1'b0;
        done    = 1'b0;
        unique case (state)
            REQ_DATA: begin
                if (stable && cls == ALL_DATA && !full) begin
                    state_n = REQ_NULL;
                    cap     = 1'b1;
                end
            end
            REQ_NULL: begin
                if (stable && cls == ALL_NULL) begin
                    state_n = REQ_DATA;
                    done    = 1'b1;
                end
            end
            default: state_n = REQ_DATA;
        endcase
    end

    // Completion is high while waiting for NULL
    always_comb begin
        bus.a_comp = (state == REQ_NULL);
    end

    // Filter, staged push, FIFO pointers, counters and sticky errors
    always_ff @(posedge clk) begin
        if (init) begin
            rp          <= '0;
            push_q      <= 1'b0;
            push_w      <= '0;
            wptr        <= '0;
            rptr        <= '0;
            cnt         <= '0;
            token_count <= '0;
            err_illegal <= 1'b0;
            err_count   <= '0;
            err_timeout <= 1'b0;
            tcnt        <= '0;
        end else begin
            rp     <= rs;
            push_q <= cap;
            push_w <= dec;
            if (push_q) wptr <= wptr + 1'b1;
            if (pop)    rptr <= rptr + 1'b1;
            cnt <= cnt + CW'(push_q) - CW'(pop);
            if (done) token_count <= token_count + 16'd1;
            if (cls == ILLEGAL) begin
                err_illegal <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
            if (state_n != state)  tcnt <= '0;
            else if (tcnt != T_MAX) tcnt <= tcnt + 1'b1;
            if (TIMEOUT > 0 && state_n == state && tcnt == T_LAST)
                err_timeout <= 1'b1;
        end
    end

    // Word storage; written one cycle after capture
    always_ff @(posedge clk) begin
        if (push_q) mem[wptr] <= push_w;
    end
endmodule

// File: tb/tb_ncl_dr_sync_receiver.sv
// Randomized scoreboard bench for ncl_dr_sync_receiver.
// Upstream stage and consumer are modelled behaviourally.
module tb_ncl_dr_sync_receiver;
    localparam int DIGITS = 2;
    localparam int SYNC   = 2;
    localparam int DEPTH  = 4;
    localparam int TMO    = 16;
    localparam int LAT    = SYNC + 2;

    logic clk = 1'b0;
    logic init = 1'b1;
    always #5 clk = ~clk;

    ncl_dr_sync_receiver_if #(.DIGITS(DIGITS)) bus ();

    logic [15:0] token_count;
    logic        err_illegal;
    logic [7:0]  err_count;
    logic        err_timeout;

    ncl_dr_sync_receiver #(
        .DIGITS      (DIGITS),
        .SYNC_STAGES (SYNC),
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT     (TMO)
    ) dut (
        .clk         (clk),
        .init        (init),
        .bus         (bus),
        .token_count (token_count),
        .err_illegal (err_illegal),
        .err_count   (err_count),
        .err_timeout (err_timeout)
    );

    int checks   = 0;
    int failures = 0;
    logic [DIGITS-1:0] expq[$];
    int tokens = 0;
    int ill_cycles = 0;
    bit rdy_rand  = 1'b0;
    bit rdy_force = 1'b1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2*DIGITS-1:0] enc(input logic [DIGITS-1:0] w);
        logic [2*DIGITS-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[2*i +: 2] = w[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_comp(input logic v, input int budget,
                             input string nm, output int n);
        n = 0;
        while (bus.a_comp !== v && n < budget) begin
            tick(1);
            n++;
        end
        chk(nm, bus.a_comp, v);
    endtask

    task automatic check_reset();
        chk("rst_a_comp", bus.a_comp, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_token_count", token_count, 0);
        chk("rst_err_illegal", err_illegal, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_err_timeout", err_timeout, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 100) begin
            tick(1);
            n++;
        end
        chk("drain_left", expq.size(), 0);
    endtask

    task automatic send(input logic [DIGITS-1:0] w, input int partial,
                        input bit lat_chk);
        logic [2*DIGITS-1:0] r;
        int n;
        if (partial > 0) begin
            r = enc(w);
            r[2*DIGITS-1:2] = '0;
            bus.a_rail = r;
            tick(partial);
        end
        bus.a_rail = enc(w);
        expq.push_back(w);
        wait_comp(1'b1, 400, "comp_rise", n);
        if (lat_chk) chk("lat_rise", n, LAT);
        if (partial > 0) begin
            r = enc(w);
            r[1:0] = 2'b00;
            bus.a_rail = r;
            tick(partial);
        end
        bus.a_rail = '0;
        wait_comp(1'b0, 50, "comp_fall", n);
        if (lat_chk) chk("lat_fall", n, LAT);
        tokens++;
        chk("token_count", token_count, tokens);
    endtask

    // Consumer ready: forced level or random
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = rdy_rand ? ($urandom_range(3) != 0) : rdy_force;
        end
    end

    // Monitor: pop and compare every accepted word
    initial begin
        logic [DIGITS-1:0] w;
        forever begin
            @(negedge clk);
            if (!init && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (expq.size() == 0) begin
                    chk("pop_unexpected", 1, 0);
                end else begin
                    w = expq.pop_front();
                    chk("out_data", bus.out_data, w);
                end
            end
        end
    end

    initial begin
        int n;
        logic [DIGITS-1:0] w;
        int exp_ec;
        bus.a_rail = '0;
        tick(2);
        check_reset();
        init = 1'b0;

        // idle NULL in REQ_DATA runs into the timeout
        tick(5);
        chk("tmo_early", err_timeout, 0);
        tick(20);
        chk("tmo_set", err_timeout, 1);
        chk("tmo_state", bus.a_comp, 0);
        init = 1'b1;
        tick(1);
        init = 1'b0;
        chk("tmo_cleared", err_timeout, 0);

        // first token: latency and one-cycle output delay
        w = 2'b01;
        bus.a_rail = enc(w);
        chk("t1_rail", bus.a_rail, 4'b0110);
        expq.push_back(w);
        wait_comp(1'b1, 20, "t1_rise", n);
        chk("t1_lat_rise", n, LAT);
        chk("t1_valid_pre", bus.out_valid, 0);
        tick(1);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_data", bus.out_data, 2'b01);
        bus.a_rail = '0;
        wait_comp(1'b0, 20, "t1_fall", n);
        chk("t1_lat_fall", n, LAT);
        tokens = 1;
        chk("t1_tokens", token_count, 1);
        repeat (4) send(DIGITS'($urandom), 0, 1'b1);
        chk("t2_tokens5", token_count, 5);
        drain();

        // backpressure with a full FIFO
        rdy_force = 1'b0;
        tick(1);
        repeat (DEPTH) send(DIGITS'($urandom), 0, 1'b1);
        w = DIGITS'($urandom);
        bus.a_rail = enc(w);
        expq.push_back(w);
        tick(12);
        chk("bp_hold", bus.a_comp, 0);
        chk("bp_valid", bus.out_valid, 1);
        rdy_force = 1'b1;
        tick(1);
        rdy_force = 1'b0;
        wait_comp(1'b1, 20, "bp_release", n);
        bus.a_rail = '0;
        wait_comp(1'b0, 20, "bp_fall", n);
        tokens++;
        chk("bp_tokens", token_count, tokens);
        rdy_force = 1'b1;
        drain();

        // partial wavefront is ignored until complete
        bus.a_rail = 4'b0001;
        tick(10);
        chk("part_comp", bus.a_comp, 0);
        chk("part_valid", bus.out_valid, 0);
        send(2'b10, 0, 1'b1);
        drain();

        // random tokens with skew and random consumer
        rdy_rand = 1'b1;
        repeat (40) send(DIGITS'($urandom), $urandom_range(2), 1'b0);
        rdy_rand = 1'b0;
        rdy_force = 1'b1;
        drain();

        // illegal digit
        bus.a_rail = 4'b0011;
        tick(3);
        ill_cycles += 3;
        bus.a_rail = '0;
        tick(LAT + 1);
        chk("ill_flag", err_illegal, 1);
        chk("ill_count3", err_count, ill_cycles);
        chk("ill_state", bus.a_comp, 0);
        chk("ill_nopush", bus.out_valid, 0);
        bus.a_rail = 4'b0011;
        tick(300);
        ill_cycles += 300;
        bus.a_rail = '0;
        tick(LAT + 1);
        exp_ec = (ill_cycles > 255) ? 255 : ill_cycles;
        chk("ill_sat", err_count, exp_ec);
        chk("ill_state2", bus.a_comp, 0);

        // reset mid-handshake, then re-capture of held DATA
        rdy_force = 1'b0;
        tick(1);
        w = DIGITS'($urandom);
        bus.a_rail = enc(w);
        expq.push_back(w);
        wait_comp(1'b1, 20, "rr_rise", n);
        tick(2);
        init = 1'b1;
        tick(1);
        check_reset();
        expq.delete();
        tokens = 0;
        init = 1'b0;
        expq.push_back(w);
        wait_comp(1'b1, 20, "rr_recapture", n);
        chk("rr_lat", n, LAT);
        rdy_force = 1'b1;
        bus.a_rail = '0;
        wait_comp(1'b0, 20, "rr_fall", n);
        tokens++;
        chk("rr_tokens", token_count, tokens);
        drain();
        tick(2);
        chk("end_valid", bus.out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
